// File: rtl/xtile_k_sequencer.sv
// Row sequencer for the X-tile loader: walks a window of K rows, handing each
// loaded row to the PE array and releasing it back to the loader.
module xtile_k_sequencer #(
    parameter int KMAX   = 1024,
    parameter int K_W    = $clog2(KMAX),
    parameter int WD_CYC = 256
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [K_W-1:0] cmd_k_base,
    input  logic [K_W:0]   cmd_k_len,
    output logic           start_k,
    output logic [K_W-1:0] k_idx,
    input  logic           row_valid,
    output logic           row_accept,
    output logic           pe_row_valid,
    input  logic           pe_row_ready,
    output logic [K_W-1:0] pe_row_k,
    output logic           pe_row_last,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int WD_W = $clog2(WD_CYC + 1);
    localparam logic [K_W+1:0] LP_KMAX    = (K_W+2)'(KMAX);
    localparam logic [WD_W-1:0] LP_WD_LAST = WD_W'(WD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ROW,
        S_PRESENT,
        S_ACCEPT,
        S_RELEASE
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [K_W-1:0]  r_k_cur, w_k_cur_nxt;
    logic [K_W:0]    r_remaining, w_remaining_nxt;
    logic [WD_W-1:0] r_wd, w_wd_nxt;
    logic            r_done, w_done_nxt;
    logic            r_err, w_err_nxt;
    logic [K_W+1:0]  w_cmd_end;

    // Widened so base+len can never wrap before the range check.
    assign w_cmd_end = {2'b00, cmd_k_base} + {1'b0, cmd_k_len};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_k_cur     <= '0;
            r_remaining <= '0;
            r_wd        <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_k_cur     <= w_k_cur_nxt;
            r_remaining <= w_remaining_nxt;
            r_wd        <= w_wd_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_k_cur_nxt     = r_k_cur;
        w_remaining_nxt = r_remaining;
        w_wd_nxt        = r_wd;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_k_len == '0) begin
                        w_done_nxt = 1'b1;
                    end else if (w_cmd_end > LP_KMAX) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_k_cur_nxt     = cmd_k_base;
                        w_remaining_nxt = cmd_k_len;
                        w_state_nxt     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                w_wd_nxt    = '0;
                w_state_nxt = S_WAIT_ROW;
            end
            S_WAIT_ROW: begin
                if (row_valid) begin
                    w_state_nxt = S_PRESENT;
                end else if (r_wd == LP_WD_LAST) begin
                    // Loader never answered: abort without releasing anything.
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wd_nxt = r_wd + WD_W'(1);
                end
            end
            S_PRESENT: begin
                if (pe_row_ready) w_state_nxt = S_ACCEPT;
            end
            S_ACCEPT: begin
                w_remaining_nxt = r_remaining - (K_W+1)'(1);
                w_state_nxt     = S_RELEASE;
            end
            S_RELEASE: begin
                if (!row_valid) begin
                    if (r_remaining == '0) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_k_cur_nxt = r_k_cur + K_W'(1);
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign cmd_ready    = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign start_k      = (r_state == S_ISSUE);
    assign k_idx        = r_k_cur;
    assign row_accept   = (r_state == S_ACCEPT);
    assign pe_row_valid = (r_state == S_PRESENT);
    assign pe_row_k     = (r_state == S_PRESENT) ? r_k_cur : '0;
    assign pe_row_last  = (r_state == S_PRESENT) && (r_remaining == (K_W+1)'(1));
    assign done         = r_done;
    assign err          = r_err;

endmodule

// File: tb/tb_xtile_k_sequencer.sv
// Bench for xtile_k_sequencer: directed scenarios plus randomized jobs, with
// loader and PE responders and a job-level reference model.
module tb_xtile_k_sequencer;

    localparam int KMAX   = 1024;
    localparam int K_W    = 10;
    localparam int WD_CYC = 256;

    logic           clk;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [K_W-1:0] cmd_k_base;
    logic [K_W:0]   cmd_k_len;
    logic           start_k;
    logic [K_W-1:0] k_idx;
    logic           row_valid;
    logic           row_accept;
    logic           pe_row_valid;
    logic           pe_row_ready;
    logic [K_W-1:0] pe_row_k;
    logic           pe_row_last;
    logic           busy;
    logic           done;
    logic           err;

    xtile_k_sequencer #(.KMAX(KMAX), .K_W(K_W), .WD_CYC(WD_CYC)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_k_base(cmd_k_base), .cmd_k_len(cmd_k_len),
        .start_k(start_k), .k_idx(k_idx),
        .row_valid(row_valid), .row_accept(row_accept),
        .pe_row_valid(pe_row_valid), .pe_row_ready(pe_row_ready),
        .pe_row_k(pe_row_k), .pe_row_last(pe_row_last),
        .busy(busy), .done(done), .err(err)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "simulation time limit");
    end

    // ---------------- counters and logs ----------------
    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int n_acc, n_done, n_err;
    int start_cyc, end_cyc;
    bit seen_start;
    logic [K_W-1:0] got_start_q[$];
    logic [K_W:0]   got_row_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- loader responder ----------------
    int ld_lat    = 4;
    int rel_hold  = 0;
    bit ld_en     = 1'b1;
    int ld_cnt    = 0;
    int rel_cnt   = 0;

    initial begin
        row_valid = 1'b0;
        forever begin
            tick();
            if (busy !== 1'b1) begin
                row_valid = 1'b0;
                ld_cnt    = 0;
                rel_cnt   = 0;
            end else begin
                if (start_k && ld_en) begin
                    ld_cnt = ld_lat;
                end else if (ld_cnt > 0) begin
                    ld_cnt--;
                    if (ld_cnt == 0) row_valid = 1'b1;
                end
                if (row_accept) begin
                    if (rel_hold == 0) row_valid = 1'b0;
                    else rel_cnt = rel_hold + 1;
                end else if (rel_cnt > 0) begin
                    rel_cnt--;
                    if (rel_cnt == 0) row_valid = 1'b0;
                end
            end
        end
    end

    // ---------------- PE responder ----------------
    int pe_stall = 0;
    bit pe_noise = 1'b0;
    int pe_cnt   = 0;

    initial begin
        pe_row_ready = 1'b0;
        forever begin
            tick();
            if (pe_row_valid === 1'b1) begin
                if (pe_cnt < pe_stall) begin
                    pe_row_ready = 1'b0;
                    pe_cnt++;
                end else begin
                    pe_row_ready = 1'b1;
                end
            end else begin
                pe_cnt       = 0;
                pe_row_ready = pe_noise ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [3:0]   pulses, prev_pulses = '0;
    bit           holding = 1'b0;
    logic [K_W-1:0] hold_k;
    bit           prev_pv = 1'b0, prev_rdy = 1'b0;
    logic [K_W:0] prev_row;

    always @(negedge clk) begin
        cyc++;
        pulses = {start_k, row_accept, done, err};
        if (pulses != 4'b0000) begin
            check("pulse_exclusive", 32'($countones(pulses) <= 1), 32'd1);
            check("pulse_single_cycle", 32'(pulses & prev_pulses), 32'd0);
        end
        prev_pulses = pulses;
        if (start_k === 1'b1) begin
            got_start_q.push_back(k_idx);
            if (!seen_start) begin
                seen_start = 1'b1;
                start_cyc  = cyc;
            end
        end
        if (row_accept === 1'b1) n_acc++;
        if (done === 1'b1) begin n_done++; end_cyc = cyc; end
        if (err === 1'b1)  begin n_err++;  end_cyc = cyc; end
        if (pe_row_valid === 1'b1 && pe_row_ready === 1'b1)
            got_row_q.push_back({pe_row_last, pe_row_k});
        if (busy !== 1'b1) begin
            holding = 1'b0;
        end else if (start_k === 1'b1) begin
            hold_k  = k_idx;
            holding = 1'b1;
        end else if (holding) begin
            check("k_idx_stable", 32'(k_idx), 32'(hold_k));
            if (row_accept === 1'b1) holding = 1'b0;
        end
        if (pe_row_valid === 1'b1 && prev_pv && !prev_rdy)
            check("pe_row_stable", 32'({pe_row_last, pe_row_k}), 32'(prev_row));
        prev_pv  = (pe_row_valid === 1'b1);
        prev_rdy = (pe_row_ready === 1'b1);
        prev_row = {pe_row_last, pe_row_k};
    end

    // ---------------- driver tasks ----------------
    task automatic start_cmd(input int base, input int len);
        got_start_q.delete();
        got_row_q.delete();
        n_acc = 0; n_done = 0; n_err = 0;
        seen_start = 1'b0; start_cyc = 0; end_cyc = 0;
        cmd_valid  = 1'b1;
        cmd_k_base = K_W'(base);
        cmd_k_len  = (K_W+1)'(len);
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (n_done + n_err > 0) break;
            tick();
        end
        check("job_end_within_budget", 32'(n_done + n_err > 0), 32'd1);
    endtask

    // Reference model: a job either finishes at once (len 0), is refused
    // (window past KMAX), or visits base..base+len-1 in order, each row
    // costing loader latency + PE stall + release hold + 4 cycles.
    task automatic check_job(input int base, input int len, input int lat,
                             input int stall, input int hold);
        logic [K_W-1:0] exp_q[$];
        logic [K_W:0]   exp_row_q[$];
        bit ok;
        ok = (len != 0) && (base + len <= KMAX);
        if (ok) begin
            for (int i = 0; i < len; i++) begin
                exp_q.push_back(K_W'(base + i));
                exp_row_q.push_back({(i == len - 1), K_W'(base + i)});
            end
        end
        check("start_count", 32'(got_start_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_start_q.size())
                check($sformatf("start_k_idx[%0d]", i), 32'(got_start_q[i]), 32'(exp_q[i]));
        check("row_count", 32'(got_row_q.size()), 32'(exp_row_q.size()));
        for (int i = 0; i < exp_row_q.size(); i++)
            if (i < got_row_q.size())
                check($sformatf("pe_row_last_k[%0d]", i), 32'(got_row_q[i]), 32'(exp_row_q[i]));
        check("row_accept_count", 32'(n_acc), ok ? 32'(len) : 32'd0);
        check("done_count", 32'(n_done), (len == 0 || ok) ? 32'd1 : 32'd0);
        check("err_count", 32'(n_err), (len != 0 && !ok) ? 32'd1 : 32'd0);
        if (ok)
            check("job_cycles", 32'(end_cyc - start_cyc), 32'(len * (lat + 4 + stall + hold)));
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    task automatic run_job(input int base, input int len, input int lat,
                           input int stall, input int hold);
        ld_lat = lat; pe_stall = stall; rel_hold = hold;
        start_cmd(base, len);
        @(negedge clk);
        if (len == 0) begin
            check("len0_done_next", 32'(done), 32'd1);
            check("len0_not_busy", 32'(busy), 32'd0);
        end else if (base + len > KMAX) begin
            check("range_err_next", 32'(err), 32'd1);
            check("range_not_busy", 32'(busy), 32'd0);
        end else begin
            check("issue_start_k", 32'(start_k), 32'd1);
            check("issue_k_idx", 32'(k_idx), 32'(base));
        end
        wait_end(3000);
        tick();
        check_job(base, len, lat, stall, hold);
    endtask

    function automatic logic [27:0] out_vec();
        return {cmd_ready, start_k, k_idx, row_accept, pe_row_valid,
                pe_row_k, pe_row_last, busy, done, err};
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [27:0] rst_vec;
        int b, l, r;
        rst_vec    = 28'h800_0000;
        rst        = 1'b0;
        cmd_valid  = 1'b0;
        cmd_k_base = '0;
        cmd_k_len  = '0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_outputs", 32'(out_vec()), 32'(rst_vec));
        tick();
        rst = 1'b1;
        tick();

        // single row, loader latency 10, PE always ready
        pe_noise = 1'b0;
        run_job(7, 1, 10, 0, 0);

        // multi-row with PE backpressure and a lingering loader row_valid
        run_job(3, 4, 3, 5, 1);

        // window boundaries
        run_job(1020, 5, 2, 0, 0);
        run_job(1020, 4, 2, 1, 0);
        run_job(9, 0, 2, 0, 0);

        // watchdog: loader stays silent
        ld_en = 1'b0;
        start_cmd(5, 2);
        wait_end(WD_CYC + 50);
        tick();
        check("wd_err_count", 32'(n_err), 32'd1);
        check("wd_done_count", 32'(n_done), 32'd0);
        check("wd_accept_count", 32'(n_acc), 32'd0);
        check("wd_start_count", 32'(got_start_q.size()), 32'd1);
        check("wd_err_latency", 32'(end_cyc - start_cyc), 32'(WD_CYC + 1));
        check("wd_idle", 32'(busy), 32'd0);
        ld_en = 1'b1;

        // command while busy is ignored
        ld_lat = 3; pe_stall = 2; rel_hold = 0;
        start_cmd(20, 3);
        repeat (4) tick();
        cmd_valid  = 1'b1;
        cmd_k_base = K_W'(500);
        cmd_k_len  = (K_W+1)'(7);
        check("busy_cmd_ready_low", 32'(cmd_ready), 32'd0);
        repeat (3) tick();
        cmd_valid = 1'b0;
        wait_end(3000);
        tick();
        check_job(20, 3, 3, 2, 0);

        // reset during PRESENT of the second row
        ld_lat = 2; pe_stall = 3; rel_hold = 0;
        start_cmd(10, 4);
        for (int i = 0; i < 300; i++) begin
            if (pe_row_valid === 1'b1 && pe_row_k == K_W'(11)) break;
            tick();
        end
        check("reached_row2_present", 32'(pe_row_valid === 1'b1 && pe_row_k == K_W'(11)), 32'd1);
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("midjob_reset_outputs", 32'(out_vec()), 32'(rst_vec));
        tick();
        rst = 1'b1;
        repeat (2) tick();
        check("midjob_accepts", 32'(n_acc), 32'd1);
        check("midjob_no_done", 32'(n_done), 32'd0);
        run_job(0, 2, 2, 0, 0);

        // randomized jobs with PE ready noise outside PRESENT
        pe_noise = 1'b1;
        for (int j = 0; j < 12; j++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                l = 0;
                b = $urandom_range(0, KMAX - 1);
            end else if (r == 1) begin
                b = $urandom_range(KMAX - 6, KMAX - 1);
                l = KMAX - b + $urandom_range(1, 3);
            end else begin
                l = $urandom_range(1, 5);
                b = $urandom_range(0, KMAX - l);
            end
            run_job(b, l, $urandom_range(1, 6), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/xtile_k_sequencer.md
XTILE_K_SEQUENCER -- requirements
Module: xtile_k_sequencer

Interface
REQ-001 SHALL have parameter KMAX, default 1024, meaning number of addressable X rows.
REQ-002 SHALL have parameter K_W, default $clog2(KMAX), meaning width of the row index.
REQ-003 SHALL have parameter WD_CYC, default 256, meaning the WAIT_ROW watchdog limit in cycles.
REQ-004 SHALL use one clock; reset is synchronous and active-low. Ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-low reset.
- cmd_valid  in  1  job request.
- cmd_ready  out  1  high only in IDLE.
- cmd_k_base  in  K_W  first row index.
- cmd_k_len  in  K_W+1  row count, range 0..KMAX.
- start_k  out  1  one-cycle pulse to the X-tile loader.
- k_idx  out  K_W  row index; held stable from start_k until row_accept.
- row_valid  in  1  loader row-complete level.
- row_accept  out  1  one-cycle release pulse to the loader.
- pe_row_valid  out  1  row available to the PE array.
- pe_row_ready  in  1  PE array consumes the row.
- pe_row_k  out  K_W  index of the presented row.
- pe_row_last  out  1  presented row is the final row of the job.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at job end.
- err  out  1  one-cycle pulse on rejected command or watchdog expiry.

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, WAIT_ROW, PRESENT, ACCEPT, RELEASE.
REQ-006 SHALL accept a command on the cycle where IDLE && cmd_valid.
REQ-007 On accept with cmd_k_len==0, SHALL pulse done on the next cycle, stay in IDLE, and never assert start_k.
REQ-008 On accept with cmd_k_base+cmd_k_len>KMAX (computed at K_W+2 bits, no wrap), SHALL pulse err on the next cycle, stay in IDLE, and issue nothing.
REQ-009 On a valid accept, SHALL latch k_cur=cmd_k_base and remaining=cmd_k_len, then move to ISSUE.
REQ-010 In ISSUE, SHALL assert start_k for exactly one cycle with k_idx=k_cur, clear the watchdog counter, and move to WAIT_ROW.
REQ-011 In WAIT_ROW, SHALL move to PRESENT on the first cycle row_valid==1; otherwise SHALL increment the watchdog counter.
REQ-012 When the watchdog counter reaches WD_CYC, SHALL pulse err, assert no row_accept, and return to IDLE (job aborted, no done).
REQ-013 In PRESENT:
- pe_row_valid=1, pe_row_k=k_cur, pe_row_last=(remaining==1).
- pe_row_valid SHALL stay high, with pe_row_k and pe_row_last stable, until pe_row_ready==1.
- On the handshake cycle, SHALL move to ACCEPT.
REQ-014 In ACCEPT, SHALL assert row_accept for exactly one cycle, decrement remaining, and move to RELEASE.
REQ-015 In RELEASE, SHALL wait for row_valid==0; if row_valid is already low on entry, SHALL proceed on that same cycle.
REQ-016 On leaving RELEASE:
- if remaining==0, SHALL pulse done and enter IDLE;
- otherwise SHALL set k_cur=k_cur+1 and enter ISSUE.
REQ-017 Minimum per-row overhead SHALL be 4 cycles beyond the loader latency and PE stall: ISSUE, PRESENT, ACCEPT, RELEASE.
REQ-018 start_k, row_accept, done and err SHALL never be high simultaneously, and none of them SHALL exceed a single cycle.
REQ-019 cmd_valid while busy SHALL be ignored: no effect and no latching.
REQ-020 pe_row_ready outside PRESENT SHALL be ignored.
REQ-021 A row_valid that is already high in ISSUE (stale) SHALL NOT satisfy WAIT_ROW until start_k has been issued.

Reset
REQ-022 While rst==0 at a clock edge, SHALL enter IDLE and drive every output to 0 except cmd_ready=1, including k_idx=0, pe_row_k=0 and err=0.
REQ-023 Reset asserted mid-job SHALL abort the job without a row_accept or done pulse; the next command after reset release SHALL start cleanly.

Verification
REQ-024 Bench SHALL cover the single-row job: base=7, len=1, loader row_valid 10 cycles after start_k, pe_row_ready tied high.
- One start_k with k_idx=7.
- pe_row_k=7 with pe_row_last=1.
- One row_accept, then done.
REQ-025 Bench SHALL cover the multi-row job with PE backpressure: base=3, len=4, pe_row_ready low for 5 cycles per row.
- start_k sequence k=3,4,5,6.
- pe_row_valid held stable during each stall.
- pe_row_last only on k=6; exactly 4 row_accept pulses, 1 done.
REQ-026 Bench SHALL cover the boundary commands:
- base=1020, len=5 -> err pulse, no start_k;
- base=1020, len=4 -> success ending at k=1023;
- len=0 -> done pulse only.
REQ-027 Bench SHALL cover the watchdog: loader never raises row_valid after start_k.
- err exactly WD_CYC cycles into WAIT_ROW.
- FSM back in IDLE; no row_accept, no done.
REQ-028 Bench SHALL cover reset mid-job: rst=0 during PRESENT of row 2 of a len=4 job.
- All outputs at reset values the next cycle.
- New job base=0, len=2 completes normally.
REQ-029 Bench SHALL cover the busy command: cmd_valid pulsed during a running job -> cmd_ready=0 and the running job's k sequence is unchanged.
